// File: rtl/word_capture_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_capture_sequencer_pkg
// Description : Shared types and defaults for the word capture path:
//               sequencer state encoding, window geometry defaults and the
//               word-width helper shared with the example store.
// Revision    : 1.0 - initial release
// ============================================================================
package word_capture_sequencer_pkg;

    // Window geometry defaults
    localparam int DEF_BIN_CYCLES = 256;
    localparam int DEF_NUM_BINS   = 50;
    localparam int DEF_BIN_W      = 16;
    localparam int DEF_MIN_BINS   = 4;
    localparam int DEF_MAX_WORDS  = 15;

    // Fixed field widths of the presented word descriptor
    localparam int IDX_W = 4;   // session slot, 0..MAX_WORDS-1
    localparam int CNT_W = 6;   // closed-bin count, 0..NUM_BINS

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_REC     = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4,
        ST_PRESENT = 3'd5
    } state_t;

    // Flattened window width: NUM_BINS counters of BIN_W bits each
    function automatic int word_width(input int num_bins, input int bin_w);
        return num_bins * bin_w;
    endfunction

endpackage : word_capture_sequencer_pkg
`default_nettype wire

// File: rtl/word_capture_sequencer_spike_bin_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : spike_bin_accumulator
// Description : Bin timer, current bin index and NUM_BINS saturating spike
//               counters. Counting and time advance only while run is high;
//               clear zeroes the whole window. The exported window shows only
//               closed bins, so a partial bin always reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_bin_accumulator
    import word_capture_sequencer_pkg::*;
#(
    parameter int BIN_CYCLES = DEF_BIN_CYCLES,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int BIN_W      = DEF_BIN_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  run,
    input  logic                                  spike,
    output logic                                  bin_close,
    output logic [CNT_W-1:0]                      closed_bins,
    output logic [word_width(NUM_BINS,BIN_W)-1:0] window
);

    localparam int                 TIMER_W    = (BIN_CYCLES > 1) ? $clog2(BIN_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIN_CYCLES - 1);

    logic [TIMER_W-1:0] bin_timer;
    logic [CNT_W-1:0]   bin_idx;
    logic               bins_full;

    // Once every bin is closed the window is frozen even if run stays high
    assign bins_full   = (bin_idx >= CNT_W'(NUM_BINS));
    assign bin_close   = run && !bins_full && (bin_timer == TIMER_LAST);
    assign closed_bins = bin_idx;

    // Bin timer wraps every BIN_CYCLES cycles and advances the bin index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_timer <= '0;
            bin_idx   <= '0;
        end else if (clear) begin
            bin_timer <= '0;
            bin_idx   <= '0;
        end else if (run && !bins_full) begin
            if (bin_timer == TIMER_LAST) begin
                bin_timer <= '0;
                bin_idx   <= bin_idx + CNT_W'(1);
            end else begin
                bin_timer <= bin_timer + TIMER_W'(1);
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
            logic [BIN_W-1:0] count;
            logic             hit;

            // A spike on the closing cycle still lands here: bin_idx moves on
            // only after this edge.
            assign hit = run && spike && (bin_idx == CNT_W'(k)) &&
                         (count != {BIN_W{1'b1}});

            // Saturating spike counter for bin k
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (hit) begin
                    count <= count + BIN_W'(1);
                end
            end

            assign window[k*BIN_W +: BIN_W] = (CNT_W'(k) < bin_idx) ? count : '0;
        end
    endgenerate

endmodule : spike_bin_accumulator
`default_nettype wire

// File: rtl/word_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : word_capture_sequencer
// Description : Captures one spoken-word example into a binned spike-count
//               window while the record button is held, then presents it to
//               the training-example store over valid/ready. Hands out up to
//               MAX_WORDS windows per session, then flags completion.
// Revision    : 1.0 - initial release
// ============================================================================
module word_capture_sequencer
    import word_capture_sequencer_pkg::*;
#(
    parameter int BIN_CYCLES = DEF_BIN_CYCLES,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int BIN_W      = DEF_BIN_W,
    parameter int MIN_BINS   = DEF_MIN_BINS,
    parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic                                  button_pressed,
    input  logic                                  clear_window,
    input  logic                                  spike_valid,
    input  logic                                  word_ready,
    output logic                                  word_valid,
    output logic [word_width(NUM_BINS,BIN_W)-1:0] word_data,
    output logic [IDX_W-1:0]                      word_index,
    output logic [CNT_W-1:0]                      bins_used,
    output logic                                  recording,
    output logic                                  discard_pulse,
    output logic                                  session_done
);

    state_t                                state;
    logic [IDX_W-1:0]                      word_count;
    logic                                  button_prev;
    logic                                  start_rec;
    logic                                  acc_clear;
    logic                                  acc_run;
    logic                                  bin_close;
    logic [CNT_W-1:0]                      closed_bins;
    logic [CNT_W-1:0]                      closed_now;
    logic [word_width(NUM_BINS,BIN_W)-1:0] window;

    // Fresh press only: a button held through PRESENT/ARMED never restarts REC
    assign start_rec  = enable && !clear_window && (state == ST_ARMED) &&
                        !session_done && !button_prev && button_pressed;
    // Window is zeroed on REC entry and whenever the session is aborted
    assign acc_clear  = clear_window || !enable || start_rec;
    assign acc_run    = (state == ST_REC);
    // A bin closing on the release cycle counts as closed
    assign closed_now = closed_bins + CNT_W'(bin_close);
    // Accumulator is frozen outside REC, so the window is stable while presented
    assign word_data  = word_valid ? window : '0;

    spike_bin_accumulator #(
        .BIN_CYCLES (BIN_CYCLES),
        .NUM_BINS   (NUM_BINS),
        .BIN_W      (BIN_W)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (acc_clear),
        .run         (acc_run),
        .spike       (spike_valid),
        .bin_close   (bin_close),
        .closed_bins (closed_bins),
        .window      (window)
    );

    // Previous button sample for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_prev <= 1'b0;
        end else begin
            button_prev <= button_pressed;
        end
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            word_count    <= '0;
            word_valid    <= 1'b0;
            word_index    <= '0;
            bins_used     <= '0;
            recording     <= 1'b0;
            discard_pulse <= 1'b0;
            session_done  <= 1'b0;
        end else begin
            discard_pulse <= 1'b0;
            if (clear_window || !enable) begin
                // Abort: drop any pending word without a handshake
                state        <= enable ? ST_ARMED : ST_IDLE;
                word_count   <= '0;
                word_valid   <= 1'b0;
                word_index   <= '0;
                bins_used    <= '0;
                recording    <= 1'b0;
                session_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (start_rec) begin
                            state     <= ST_REC;
                            recording <= 1'b1;
                        end
                    end
                    ST_REC: begin
                        if (!button_pressed) begin
                            recording <= 1'b0;
                            if (closed_now >= CNT_W'(MIN_BINS)) begin
                                state      <= ST_PRESENT;
                                word_valid <= 1'b1;
                                word_index <= word_count;
                                bins_used  <= closed_now;
                            end else begin
                                state         <= ST_DISCARD;
                                discard_pulse <= 1'b1;
                            end
                        end else if (closed_now == CNT_W'(NUM_BINS)) begin
                            state     <= ST_HOLD;
                            recording <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (!button_pressed) begin
                            state      <= ST_PRESENT;
                            word_valid <= 1'b1;
                            word_index <= word_count;
                            bins_used  <= CNT_W'(NUM_BINS);
                        end
                    end
                    ST_DISCARD: begin
                        state <= ST_ARMED;
                    end
                    ST_PRESENT: begin
                        if (word_ready) begin
                            state      <= ST_ARMED;
                            word_valid <= 1'b0;
                            word_index <= '0;
                            bins_used  <= '0;
                            word_count <= word_count + IDX_W'(1);
                            if (word_count == IDX_W'(MAX_WORDS - 1)) begin
                                session_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : word_capture_sequencer
`default_nettype wire

// File: tb/tb_word_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_capture_sequencer
// Description : Directed bench for word_capture_sequencer with a scoreboard of
//               expected words. BIN_W is reduced to 8 so that counter
//               saturation is reachable inside one 256-cycle bin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_capture_sequencer;
    import word_capture_sequencer_pkg::*;

    localparam int TB_BIN_CYCLES = 256;
    localparam int TB_NUM_BINS   = 50;
    localparam int TB_BIN_W      = 8;
    localparam int TB_MIN_BINS   = 4;
    localparam int TB_MAX_WORDS  = 15;
    localparam int WW            = TB_NUM_BINS * TB_BIN_W;
    localparam logic [TB_BIN_W-1:0] MAXV = {TB_BIN_W{1'b1}};

    typedef struct packed {
        logic [WW-1:0]    data;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] used;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             button_pressed;
    logic             clear_window;
    logic             spike_valid;
    logic             word_ready;
    logic             word_valid;
    logic [WW-1:0]    word_data;
    logic [IDX_W-1:0] word_index;
    logic [CNT_W-1:0] bins_used;
    logic             recording;
    logic             discard_pulse;
    logic             session_done;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   exp_count;

    word_capture_sequencer #(
        .BIN_CYCLES (TB_BIN_CYCLES),
        .NUM_BINS   (TB_NUM_BINS),
        .BIN_W      (TB_BIN_W),
        .MIN_BINS   (TB_MIN_BINS),
        .MAX_WORDS  (TB_MAX_WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .button_pressed (button_pressed),
        .clear_window   (clear_window),
        .spike_valid    (spike_valid),
        .word_ready     (word_ready),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_index     (word_index),
        .bins_used      (bins_used),
        .recording      (recording),
        .discard_pulse  (discard_pulse),
        .session_done   (session_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spike pattern: 0 = three per bin, 1 = every cycle of bin 0 plus the
    // closing cycle of each later bin, otherwise random at 1/4 density.
    function automatic bit spike_for(input int mode, input int c);
        int off;
        off = c % TB_BIN_CYCLES;
        case (mode)
            0:       return (off == 10) || (off == 20) || (off == 30);
            1:       return (c < TB_BIN_CYCLES) || (off == TB_BIN_CYCLES - 1);
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    // Press, hold for cycles 0..last-1, release sampled in cycle 'last'.
    task automatic capture(input int last, input int mode);
        logic [TB_BIN_W-1:0] exp_bins [TB_NUM_BINS];
        logic [WW-1:0]       data;
        int                  closed;
        int                  b;
        bit                  s;
        exp_t                e;
        for (int i = 0; i < TB_NUM_BINS; i++) exp_bins[i] = '0;
        button_pressed = 1'b0;
        spike_valid    = 1'b0;
        repeat (3) @(negedge clk);
        button_pressed = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= last; c++) begin
            if (c == 0) chk("recording_on_entry", recording, 1);
            if (c == last) chk("no_valid_before_release", word_valid, 0);
            s = spike_for(mode, c);
            spike_valid = s;
            if (c == last) button_pressed = 1'b0;
            b = c / TB_BIN_CYCLES;
            if (s && b < TB_NUM_BINS && exp_bins[b] != MAXV) exp_bins[b] = exp_bins[b] + 1'b1;
            @(negedge clk);
        end
        spike_valid = 1'b0;
        closed = (last + 1) / TB_BIN_CYCLES;
        if (closed > TB_NUM_BINS) closed = TB_NUM_BINS;
        if (closed >= TB_MIN_BINS) begin
            data = '0;
            for (int i = 0; i < closed; i++) data[i*TB_BIN_W +: TB_BIN_W] = exp_bins[i];
            e.data = data;
            e.idx  = IDX_W'(exp_count);
            e.used = CNT_W'(closed);
            sb.push_back(e);
            chk("valid_latency", word_valid, 1);
        end else begin
            chk("discard_pulse_high", discard_pulse, 1);
            chk("discard_no_valid", word_valid, 0);
            @(negedge clk);
            chk("discard_pulse_single", discard_pulse, 0);
        end
    endtask

    // Hold off ready for 'stall' cycles, then complete the handshake.
    task automatic accept(input int stall);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        word_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", word_valid, 1);
            chk("stall_data", word_data, e.data);
            @(negedge clk);
        end
        chk("word_valid", word_valid, 1);
        chk("word_data", word_data, e.data);
        chk("word_index", word_index, e.idx);
        chk("bins_used", bins_used, e.used);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        exp_count++;
        chk("valid_drop_after_accept", word_valid, 0);
    endtask

    initial begin
        exp_t dropped;
        vectors        = 0;
        miscompares    = 0;
        exp_count      = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        button_pressed = 1'b0;
        clear_window   = 1'b0;
        spike_valid    = 1'b0;
        word_ready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_word_index", word_index, 0);
        chk("rst_bins_used", bins_used, 0);
        chk("rst_recording", recording, 0);
        chk("rst_discard", discard_pulse, 0);
        chk("rst_session_done", session_done, 0);
        rst_n  = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Too short: three full bins, then release
        capture(3 * TB_BIN_CYCLES, 0);
        // Ten bins, three spikes each; slot stays 0 after the discard
        capture(10 * TB_BIN_CYCLES, 0);
        accept(0);
        // Held past 50 bins, spikes continuing; ready stalled 100 cycles
        capture(51 * TB_BIN_CYCLES + 100, 0);
        accept(100);
        // Saturation in bin 0; closing-cycle spikes; release on a bin close
        capture(4 * TB_BIN_CYCLES - 1, 1);
        accept(3);
        // Fill the rest of the session with random short words
        for (int w = 3; w < TB_MAX_WORDS; w++) begin
            capture(4 * TB_BIN_CYCLES, 2);
            accept(w % 3);
        end
        chk("session_done_set", session_done, 1);

        // Press while the session is complete must be ignored
        repeat (3) @(negedge clk);
        button_pressed = 1'b1;
        repeat (600) @(negedge clk);
        chk("done_blocks_recording", recording, 0);
        chk("done_no_word", word_valid, 0);
        button_pressed = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_no_discard", discard_pulse, 0);
        chk("done_sticky", session_done, 1);

        // clear_window restarts the session count
        clear_window = 1'b1;
        @(negedge clk);
        clear_window = 1'b0;
        exp_count    = 0;
        chk("clear_session_done", session_done, 0);
        capture(4 * TB_BIN_CYCLES, 2);
        chk("clear_restart_index", word_index, 0);
        // clear_window during PRESENT drops the word without handshake
        clear_window = 1'b1;
        @(negedge clk);
        clear_window = 1'b0;
        dropped = sb.pop_front();
        chk("clear_drops_valid", word_valid, 0);
        chk("clear_drops_used", bins_used, 0);

        // Asynchronous reset in the middle of a recording
        repeat (3) @(negedge clk);
        button_pressed = 1'b1;
        for (int c = 0; c < 300; c++) begin
            spike_valid = spike_for(0, c);
            @(negedge clk);
        end
        chk("pre_reset_recording", recording, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_recording", recording, 0);
        chk("async_rst_valid", word_valid, 0);
        chk("async_rst_data", word_data, 0);
        chk("async_rst_index", word_index, 0);
        chk("async_rst_used", bins_used, 0);
        chk("async_rst_discard", discard_pulse, 0);
        chk("async_rst_done", session_done, 0);
        spike_valid    = 1'b0;
        button_pressed = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 0;
        // First word after reset lands in slot 0 with a clean window
        capture(5 * TB_BIN_CYCLES + 17, 0);
        accept(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_word_capture_sequencer
`default_nettype wire
